// File: rtl/rvvi_host_ack_rx_if.sv
// Receive-stream and host-acknowledge bundle for rvvi_host_ack_rx.
// master: the MAC RX side, which drives the Rx* beat signals and observes the
//         acknowledge outputs.
// slave : the parser, which consumes Rx* and drives HostInstrValid,
//         HostFrameCount, GoodFrames and DroppedFrames.
interface rvvi_host_ack_rx_if #(
    parameter int unsigned FRAME_COUNT_WIDTH = 16
) ();
    logic [31:0]                  RxData;
    logic [3:0]                   RxKeep;
    logic                         RxValid;
    logic                         RxLast;
    logic                         RxUser;
    logic                         HostInstrValid;
    logic [FRAME_COUNT_WIDTH-1:0] HostFrameCount;
    logic [15:0]                  GoodFrames;
    logic [15:0]                  DroppedFrames;

    modport master (
        output RxData, RxKeep, RxValid, RxLast, RxUser,
        input  HostInstrValid, HostFrameCount, GoodFrames, DroppedFrames
    );

    modport slave (
        input  RxData, RxKeep, RxValid, RxLast, RxUser,
        output HostInstrValid, HostFrameCount, GoodFrames, DroppedFrames
    );
endinterface

// File: rtl/rvvi_host_ack_rx.sv
// Host acknowledgement frame parser for the RVVI Ethernet trace path.
// Checks the L2 header of each received frame (destination MAC, optional
// source MAC, EtherType), extracts the 16-bit acknowledged frame count from
// wire bytes 14-15 and pulses HostInstrValid one cycle after the last beat of
// every accepted frame. Rejected frames only bump DroppedFrames.
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset; parser re-synchronises to the
//            next frame boundary afterwards
//   rx_if  - slave side: Rx* 32-bit beat stream in, host-acknowledge and
//            frame counters out (all registered)
module rvvi_host_ack_rx #(
    parameter logic [47:0]  DUT_MAC           = 48'h8F54_0000_1654,
    parameter logic [47:0]  HOST_MAC          = 48'h6805_CA3A_B3A5,
    parameter logic [15:0]  ETHER_TYPE        = 16'h88B5,
    parameter bit           CHECK_SRC         = 1'b1,
    parameter int unsigned  FRAME_COUNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    rvvi_host_ack_rx_if.slave  rx_if
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned FCW    = FRAME_COUNT_WIDTH;

    // Expected header words as they appear on RxData (wire byte 0 in [7:0]).
    localparam logic [31:0] EXP_W0 = {DUT_MAC[23:16], DUT_MAC[31:24],
                                      DUT_MAC[39:32], DUT_MAC[47:40]};
    localparam logic [31:0] EXP_W1 = {HOST_MAC[39:32], HOST_MAC[47:40],
                                      DUT_MAC[7:0],    DUT_MAC[15:8]};
    localparam logic [31:0] EXP_W2 = {HOST_MAC[7:0],   HOST_MAC[15:8],
                                      HOST_MAC[23:16], HOST_MAC[31:24]};
    localparam logic [31:0] EXP_W3 = {16'h0000, ETHER_TYPE[7:0], ETHER_TYPE[15:8]};

    // Compare masks; source-MAC bytes drop out when CHECK_SRC is 0, and the
    // count bytes of beat 3 are never compared.
    localparam logic [31:0] MSK_W0 = 32'hFFFF_FFFF;
    localparam logic [31:0] MSK_W1 = CHECK_SRC ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    localparam logic [31:0] MSK_W2 = CHECK_SRC ? 32'hFFFF_FFFF : 32'h0000_0000;
    localparam logic [31:0] MSK_W3 = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_HDR   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                bad_q, bad_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [FCW-1:0]      hfc_q, hfc_d;
    logic [CNT_W-1:0]    good_q, good_d;
    logic [CNT_W-1:0]    drop_q, drop_d;

    logic [31:0]         exp_word_c;
    logic [31:0]         exp_mask_c;
    logic                mism_c;
    logic [CNT_W-1:0]    field_c;
    logic                finish_c;
    logic                accept_c;
    logic [CNT_W-1:0]    acc_cnt_c;
    logic                unused_c;

    // Bytes 14 (MSB) and 15 (LSB) sit in lanes 2 and 3 of beat 3.
    assign field_c  = {rx_if.RxData[23:16], rx_if.RxData[31:24]};
    assign unused_c = ^{rx_if.RxKeep[1:0], field_c};

    // Header word/mask for the beat currently being compared.
    always_comb begin
        exp_word_c = EXP_W0;
        exp_mask_c = MSK_W0;
        case (beat_q)
            2'd1: begin exp_word_c = EXP_W1; exp_mask_c = MSK_W1; end
            2'd2: begin exp_word_c = EXP_W2; exp_mask_c = MSK_W2; end
            2'd3: begin exp_word_c = EXP_W3; exp_mask_c = MSK_W3; end
            default: ;
        endcase
        mism_c = |((rx_if.RxData ^ exp_word_c) & exp_mask_c);
    end

    // Next-state, frame verdict and output computation.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        bad_d     = bad_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        hfc_d     = hfc_q;
        good_d    = good_q;
        drop_d    = drop_q;
        finish_c  = 1'b0;
        accept_c  = 1'b0;
        acc_cnt_c = cnt_q;

        case (state_q)
            ST_SYNC: begin
                // Wait for a gap or a frame end before trusting beat 0.
                if (!rx_if.RxValid || rx_if.RxLast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rx_if.RxValid) begin
                    bad_d   = mism_c | rx_if.RxUser;
                    beat_d  = BEAT_W'(1);
                    state_d = ST_HDR;
                    finish_c = rx_if.RxLast;
                end
            end
            ST_HDR: begin
                if (rx_if.RxValid) begin
                    bad_d = bad_q | mism_c | rx_if.RxUser;
                    if (beat_q == BEAT_W'(3)) begin
                        cnt_d     = field_c;
                        acc_cnt_c = field_c;
                        if (rx_if.RxLast) begin
                            finish_c = 1'b1;
                            accept_c = !bad_d && (rx_if.RxKeep[3:2] == 2'b11);
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        beat_d   = beat_q + BEAT_W'(1);
                        finish_c = rx_if.RxLast;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_if.RxValid) begin
                    bad_d = bad_q | rx_if.RxUser;
                    if (rx_if.RxLast) begin
                        finish_c = 1'b1;
                        accept_c = !bad_d;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (finish_c) begin
            state_d = ST_IDLE;
            beat_d  = '0;
            bad_d   = 1'b0;
            if (accept_c) begin
                valid_d = 1'b1;
                hfc_d   = acc_cnt_c[FCW-1:0];
                good_d  = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
            end else begin
                drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
            beat_q  <= '0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            hfc_q   <= '0;
            good_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            hfc_q   <= hfc_d;
            good_q  <= good_d;
            drop_q  <= drop_d;
        end
    end

    assign rx_if.HostInstrValid = valid_q;
    assign rx_if.HostFrameCount = hfc_q;
    assign rx_if.GoodFrames     = good_q;
    assign rx_if.DroppedFrames  = drop_q;

endmodule

// File: tb/tb_rvvi_host_ack_rx.sv
// Bench for rvvi_host_ack_rx: two instances (16-bit and 8-bit count output)
// share one directed beat stream; accepted frames push expectations into
// queues that a negedge monitor pops whenever HostInstrValid is seen.
module tb_rvvi_host_ack_rx;

    localparam logic [47:0] DMAC = 48'h8F54_0000_1654;
    localparam logic [47:0] HMAC = 48'h6805_CA3A_B3A5;
    localparam logic [15:0] ET   = 16'h88B5;

    typedef struct {
        logic [15:0] cnt;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;

    logic [15:0] exp_good = '0;
    logic [15:0] exp_drop = '0;
    logic [15:0] exp_hfc  = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rvvi_host_ack_rx_if #(.FRAME_COUNT_WIDTH(16)) a_if ();
    rvvi_host_ack_rx_if #(.FRAME_COUNT_WIDTH(8))  b_if ();

    assign b_if.RxData  = a_if.RxData;
    assign b_if.RxKeep  = a_if.RxKeep;
    assign b_if.RxValid = a_if.RxValid;
    assign b_if.RxLast  = a_if.RxLast;
    assign b_if.RxUser  = a_if.RxUser;

    rvvi_host_ack_rx #(
        .DUT_MAC(DMAC), .HOST_MAC(HMAC), .ETHER_TYPE(ET),
        .CHECK_SRC(1'b1), .FRAME_COUNT_WIDTH(16)
    ) dut16 (
        .clk(clk), .reset(reset), .rx_if(a_if)
    );

    rvvi_host_ack_rx #(
        .DUT_MAC(DMAC), .HOST_MAC(HMAC), .ETHER_TYPE(ET),
        .CHECK_SRC(1'b1), .FRAME_COUNT_WIDTH(8)
    ) dut8 (
        .clk(clk), .reset(reset), .rx_if(b_if)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Pulse monitor: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (a_if.HostInstrValid === 1'b1) begin
            n_vec++;
            if (q16.size() == 0) begin
                n_fail++;
                $display("FAIL pulse16: unexpected pulse, count %h at cycle %0d", a_if.HostFrameCount, cyc);
            end else begin
                e16 = q16.pop_front();
                if (a_if.HostFrameCount !== e16.cnt || cyc != e16.at) begin
                    n_fail++;
                    $display("FAIL pulse16: got count %h at cycle %0d, want %h at cycle %0d",
                             a_if.HostFrameCount, cyc, e16.cnt, e16.at);
                end
            end
        end
        if (b_if.HostInstrValid === 1'b1) begin
            n_vec++;
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL pulse8: unexpected pulse, count %h at cycle %0d", b_if.HostFrameCount, cyc);
            end else begin
                e8 = q8.pop_front();
                if (b_if.HostFrameCount !== e8.cnt[7:0] || cyc != e8.at) begin
                    n_fail++;
                    $display("FAIL pulse8: got count %h at cycle %0d, want %h at cycle %0d",
                             b_if.HostFrameCount, cyc, e8.cnt[7:0], e8.at);
                end
            end
        end
    end

    function automatic logic [31:0] hdr_word(input int k, input logic [47:0] dst,
                                             input logic [47:0] src, input logic [15:0] et,
                                             input logic [15:0] cnt);
        logic [127:0] h;
        logic [7:0]   b [16];
        h = {dst, src, et, cnt};
        for (int i = 0; i < 16; i++) b[i] = h[127-8*i -: 8];
        return {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_if.RxValid = 1'b0;
            a_if.RxLast  = 1'b0;
            a_if.RxUser  = 1'b0;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                             input logic last, input logic user);
        @(negedge clk);
        a_if.RxValid = 1'b1;
        a_if.RxData  = d;
        a_if.RxKeep  = k;
        a_if.RxLast  = last;
        a_if.RxUser  = user;
    endtask

    // Sends one frame; acc is the hand-derived verdict for this vector.
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] et, input logic [15:0] cnt,
                              input int nbeats, input logic [3:0] last_keep,
                              input int user_beat, input int gap_after, input int gap_len,
                              input bit acc);
        int   last_cyc;
        exp_t e;
        logic [31:0] d;
        last_cyc = 0;
        for (int k = 0; k < nbeats; k++) begin
            d = (k < 4) ? hdr_word(k, dst, src, et, cnt) : (32'hDEAD_0000 | 32'(k));
            send_beat(d, (k == nbeats - 1) ? last_keep : 4'hF, k == nbeats - 1, k == user_beat);
            if (k == nbeats - 1) last_cyc = cyc;
            if (k == gap_after) idle(gap_len);
        end
        if (acc) begin
            e.cnt = cnt;
            e.at  = last_cyc + 1;
            q16.push_back(e);
            q8.push_back(e);
            exp_hfc  = cnt;
            exp_good = (exp_good == 16'hFFFF) ? exp_good : exp_good + 16'd1;
        end else begin
            exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
        end
    endtask

    task automatic checkpoint(input string tag);
        idle(3);
        chk({tag, ".good"},  32'(a_if.GoodFrames),     32'(exp_good));
        chk({tag, ".drop"},  32'(a_if.DroppedFrames),  32'(exp_drop));
        chk({tag, ".hfc16"}, 32'(a_if.HostFrameCount), 32'(exp_hfc));
        chk({tag, ".hfc8"},  32'(b_if.HostFrameCount), 32'(exp_hfc[7:0]));
        chk({tag, ".drop8"}, 32'(b_if.DroppedFrames),  32'(exp_drop));
        chk({tag, ".pend"},  32'(q16.size() + q8.size()), 32'd0);
    endtask

    task automatic model_reset();
        q16.delete();
        q8.delete();
        exp_good = '0;
        exp_drop = '0;
        exp_hfc  = '0;
    endtask

    initial begin
        a_if.RxValid = 1'b0;
        a_if.RxData  = '0;
        a_if.RxKeep  = 4'h0;
        a_if.RxLast  = 1'b0;
        a_if.RxUser  = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.valid", 32'(a_if.HostInstrValid), 32'd0);
        chk("rst.hfc",   32'(a_if.HostFrameCount), 32'd0);
        chk("rst.good",  32'(a_if.GoodFrames),     32'd0);
        chk("rst.drop",  32'(a_if.DroppedFrames),  32'd0);
        reset = 1'b0;
        idle(2);

        // Basic good frame.
        send_frame(DMAC, HMAC, ET, 16'h1234, 4, 4'hF, -1, -1, 0, 1'b1);
        checkpoint("good1");

        // Header mismatches.
        send_frame(DMAC ^ 48'h0000_0000_00FF, HMAC, ET, 16'h0007, 4, 4'hF, -1, -1, 0, 1'b0);
        checkpoint("dstbad");
        send_frame(DMAC, HMAC, 16'h0800, 16'h0007, 4, 4'hF, -1, -1, 0, 1'b0);
        checkpoint("etbad");
        send_frame(48'h1111_2222_3333, HMAC, ET, 16'h0009, 4, 4'hF, -1, -1, 0, 1'b0);
        send_frame(DMAC, 48'h0000_0000_0001, ET, 16'h000A, 4, 4'hF, -1, -1, 0, 1'b0);
        checkpoint("macbad");

        // Runts and final-beat keep.
        send_frame(DMAC, HMAC, ET, 16'h0011, 3, 4'hF, -1, -1, 0, 1'b0);
        checkpoint("runt3");
        send_frame(DMAC, HMAC, ET, 16'h0012, 4, 4'h3, -1, -1, 0, 1'b0);
        checkpoint("keep3");
        send_frame(DMAC, HMAC, ET, 16'h5A5A, 4, 4'hF, -1, -1, 0, 1'b1);
        checkpoint("keepF");

        // Long frame with an in-frame gap.
        send_frame(DMAC, HMAC, ET, 16'hBEEF, 8, 4'h1, -1, 4, 2, 1'b1);
        checkpoint("long");
        send_frame(DMAC, HMAC, ET, 16'h0013, 8, 4'hF, 7, -1, 0, 1'b0);
        checkpoint("userlast");

        // Back-to-back frames.
        send_frame(DMAC, HMAC, ET, 16'h0001, 4, 4'hF, -1, -1, 0, 1'b1);
        send_frame(DMAC, HMAC, ET, 16'h0002, 4, 4'hF, -1, -1, 0, 1'b1);
        send_frame(DMAC, HMAC, ET, 16'h0003, 4, 4'hF, -1, -1, 0, 1'b1);
        checkpoint("b2b");
        send_frame(DMAC, HMAC, ET, 16'h0001, 4, 4'hF, -1, -1, 0, 1'b1);
        send_frame(DMAC, HMAC, ET, 16'h0002, 4, 4'hF,  1, -1, 0, 1'b0);
        send_frame(DMAC, HMAC, ET, 16'h0003, 4, 4'hF, -1, -1, 0, 1'b1);
        checkpoint("b2buser");

        // Reset during beat 2; beat 3 must not be parsed as a header.
        send_beat(hdr_word(0, DMAC, HMAC, ET, 16'h0077), 4'hF, 1'b0, 1'b0);
        send_beat(hdr_word(1, DMAC, HMAC, ET, 16'h0077), 4'hF, 1'b0, 1'b0);
        send_beat(hdr_word(2, DMAC, HMAC, ET, 16'h0077), 4'hF, 1'b0, 1'b0);
        reset = 1'b1;
        send_beat(hdr_word(3, DMAC, HMAC, ET, 16'h0077), 4'hF, 1'b1, 1'b0);
        reset = 1'b0;
        model_reset();
        idle(1);
        chk("midrst.good", 32'(a_if.GoodFrames),    32'd0);
        chk("midrst.drop", 32'(a_if.DroppedFrames), 32'd0);
        send_frame(DMAC, HMAC, ET, 16'h0042, 4, 4'hF, -1, -1, 0, 1'b1);
        checkpoint("midrst");

        // DroppedFrames saturation via single-beat runts.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(1);
        for (int i = 0; i < 65535; i++) begin
            send_frame(DMAC, HMAC, ET, 16'h0000, 1, 4'hF, -1, -1, 0, 1'b0);
        end
        checkpoint("sat");
        send_frame(DMAC ^ 48'h0000_0000_00FF, HMAC, ET, 16'h0005, 4, 4'hF, -1, -1, 0, 1'b0);
        checkpoint("satbad");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rvvi_host_ack_rx.md
Name: rvvi_host_ack_rx

Overview:
- Receive-side parser for host acknowledgement frames in the RVVI Ethernet trace path.
- Consumes the 32-bit receive stream from the Ethernet MAC RX path.
- Validates the L2 header and extracts the 16-bit acknowledged frame count.
- Drives the active list's host-acknowledge port: HostInstrValid and HostFrameCount.

Parameters:
- DUT_MAC, 48'h8F54_0000_1654, destination MAC that accepted frames must carry.
- HOST_MAC, 48'h6805_CA3A_B3A5, source MAC that accepted frames must carry when CHECK_SRC=1.
- ETHER_TYPE, 16'h88B5, required EtherType.
- CHECK_SRC, 1, 1 = enforce the source-MAC match; 0 = ignore the source MAC.
- FRAME_COUNT_WIDTH, 16, output width. Legal range is 1..16; the output takes the low bits of the 16-bit wire field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- RxData  in  32  stream data; byte n of a beat is RxData[8n+7:8n]; wire byte 0 is carried first
- RxKeep  in  4  byte enables; checked only on the final beat
- RxValid  in  1  beat valid; there is no backpressure, so every valid beat is consumed
- RxLast  in  1  last beat of the frame
- RxUser  in  1  MAC error flag; when set on any beat, the whole frame is bad
- HostInstrValid  out  1  one-cycle pulse per accepted frame
- HostFrameCount  out  FRAME_COUNT_WIDTH  acknowledged count; held until the next accepted frame
- GoodFrames  out  16  saturating count of accepted frames
- DroppedFrames  out  16  saturating count of rejected frames

Behaviour:
- Frame layout (wire bytes, multi-byte fields MSB first):
  - bytes 0-5: destination MAC
  - bytes 6-11: source MAC
  - bytes 12-13: EtherType
  - bytes 14-15: frame count
  - bytes 16 and beyond: ignored
  - Beat k carries bytes 4k..4k+3.
- Reset values: HostInstrValid=0, HostFrameCount=0, GoodFrames=0, DroppedFrames=0, state=SYNC, beat index=0, error flags cleared.
- State SYNC:
  - Discards beats.
  - Goes to IDLE on any cycle with RxValid=0.
  - Goes to IDLE on a valid beat with RxLast=1; that beat is discarded.
  - Frames discarded in SYNC are not counted.
- State IDLE: a valid beat is treated as beat 0. Compare it, set beat index=1, and go to HDR. If RxLast=1 on that beat, finish the frame immediately as a runt.
- State HDR:
  - Advances one header beat per valid beat and compares fields as they arrive.
  - Sets a sticky Bad flag on any of: MAC mismatch, EtherType mismatch, or RxUser=1.
  - Latches bytes 14-15 from beat 3.
  - After beat 3 with RxLast=0, go to DRAIN.
- State DRAIN: consume beats until RxLast. The only check applied is RxUser, which sets Bad.
- Frame finish (the valid beat with RxLast=1), state returns to IDLE:
  - Accept when: Bad=0, at least 4 beats received, and the RxUser of this beat is 0.
  - Additionally, if the final beat is beat 3, RxKeep[3:2] must be 2'b11.
  - Otherwise reject.
- Accept, effective in the cycle after the last beat:
  - HostInstrValid=1 for exactly one cycle.
  - HostFrameCount = {byte14, byte15}[FRAME_COUNT_WIDTH-1:0].
  - GoodFrames += 1, saturating at 16'hFFFF.
- Reject: DroppedFrames += 1 (saturating) in the cycle after the last beat. HostInstrValid stays 0 and HostFrameCount is unchanged.
- Latency: exactly 1 cycle from the RxLast beat to the HostInstrValid pulse.
- RxValid=0 cycles inside a frame: hold state; no timeout.
- Back-to-back frames: a beat that follows RxLast directly is beat 0 of the next frame. A pulse for frame N may coincide with the comparison of beat 0 of frame N+1.
- The block does no sequence checking. Duplicate or out-of-order counts are forwarded unchanged, because the active list handles replay.
- Reset asserted mid-frame: all state returns to reset values and the block enters SYNC, so the remaining beats of the partial frame are never parsed as a header.

Test Plan:
- Reset, idle gap, then a 4-beat good frame with count 0x1234 and RxKeep=4'hF on the last beat -> HostInstrValid high for 1 cycle, 1 cycle after RxLast; HostFrameCount=0x1234; GoodFrames=1; DroppedFrames=0.
- Good header but destination MAC byte 5 flipped, count 0x0007 -> no pulse; HostFrameCount keeps its previous value; DroppedFrames=1. Repeat with EtherType 0x0800 -> DroppedFrames=2.
- Runt: RxLast on beat 2 -> DroppedFrames+1, no pulse. Final beat 3 with RxKeep=4'h3 -> dropped. Same frame with RxKeep=4'hF -> accepted.
- 8-beat good frame carrying count 0xBEEF and 16 junk bytes, with RxValid low for 2 cycles after beat 4 -> exactly one pulse, 1 cycle after beat 7; HostFrameCount=0xBEEF. With FRAME_COUNT_WIDTH=8 -> HostFrameCount=0xEF.
- Three back-to-back good frames (counts 1, 2, 3) with no idle cycles -> three pulses spaced 4 cycles apart, in order 1, 2, 3; GoodFrames=3. RxUser=1 on beat 1 of the middle frame -> pulses for 1 and 3 only; DroppedFrames=1.
- Reset during beat 2 of a good frame; the remaining beats arrive without a gap, then an idle cycle, then a good frame with count 0x0042 -> partial frame ignored and counters stay 0; then one pulse with HostFrameCount=0x0042 and GoodFrames=1. Separately, drive DroppedFrames to 16'hFFFF, send a bad frame -> DroppedFrames stays 16'hFFFF.
